// File: rtl/cam_config.sv
// Camera register loader: walks a config ROM and issues SCCB register writes,
// honouring end-of-table and fixed-delay marker entries.
module cam_config #(
   parameter int ROM_DEPTH    = 76,
   parameter int DELAY_CYCLES = 1250000,
   localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
   input  logic          i_sysclk,
   input  logic          i_rstn,
   input  logic          i_cfg_start,
   output logic [AW-1:0] o_rom_addr,
   input  logic [15:0]   i_rom_data,
   output logic          o_sccb_start,
   output logic [7:0]    o_sccb_addr,
   output logic [7:0]    o_sccb_data,
   input  logic          i_sccb_ready,
   input  logic          i_sccb_done,
   output logic          o_busy,
   output logic          o_done
);

   localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [DW-1:0] DELAY_LOAD = DW'(DELAY_CYCLES - 1);
   localparam logic [AW-1:0] LAST_ADDR  = AW'(ROM_DEPTH - 1);
   localparam logic [15:0]   END_MARK   = 16'hFFFF;
   localparam logic [15:0]   DELAY_MARK = 16'hFFF0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      WRITE,
      WAIT_DONE,
      DELAY,
      FINISH
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic          sccb_start_q, sccb_start_d;
   logic [7:0]    sccb_addr_q, sccb_addr_d;
   logic [7:0]    sccb_data_q, sccb_data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [DW-1:0] delay_cnt_q, delay_cnt_d;
   logic          done_early_q, done_early_d;
   logic          advance;

   always_ff @(posedge i_sysclk) begin
      if (!i_rstn) begin
         state_q      <= IDLE;
         rom_addr_q   <= '0;
         sccb_start_q <= 1'b0;
         sccb_addr_q  <= '0;
         sccb_data_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         delay_cnt_q  <= '0;
         done_early_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rom_addr_q   <= rom_addr_d;
         sccb_start_q <= sccb_start_d;
         sccb_addr_q  <= sccb_addr_d;
         sccb_data_q  <= sccb_data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         delay_cnt_q  <= delay_cnt_d;
         done_early_q <= done_early_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rom_addr_d   = rom_addr_q;
      sccb_start_d = sccb_start_q;
      sccb_addr_d  = sccb_addr_q;
      sccb_data_d  = sccb_data_q;
      busy_d       = busy_q;
      done_d       = done_q;
      delay_cnt_d  = delay_cnt_q;
      done_early_d = done_early_q;
      advance      = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_cfg_start) begin
               rom_addr_d = '0;
               done_d     = 1'b0;
               busy_d     = 1'b1;
               state_d    = FETCH;
            end
         end
         FETCH: state_d = DECODE;
         DECODE: begin
            if (i_rom_data == END_MARK) begin
               state_d = FINISH;
            end else if (i_rom_data == DELAY_MARK) begin
               delay_cnt_d = DELAY_LOAD;
               state_d     = DELAY;
            end else begin
               sccb_addr_d  = i_rom_data[15:8];
               sccb_data_d  = i_rom_data[7:0];
               sccb_start_d = 1'b1;
               state_d      = WRITE;
            end
         end
         WRITE: begin
            // A completion pulse coinciding with the accept is remembered so it is not lost.
            if (sccb_start_q && i_sccb_ready) begin
               sccb_start_d = 1'b0;
               done_early_d = i_sccb_done;
               state_d      = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (i_sccb_done || done_early_q) begin
               done_early_d = 1'b0;
               advance      = 1'b1;
            end
         end
         DELAY: begin
            if (delay_cnt_q == '0) begin
               advance = 1'b1;
            end else begin
               delay_cnt_d = delay_cnt_q - 1'b1;
            end
         end
         FINISH: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The last ROM entry ends the sequence even without an end marker.
      if (advance) begin
         if (rom_addr_q == LAST_ADDR) begin
            state_d = FINISH;
         end else begin
            rom_addr_d = rom_addr_q + 1'b1;
            state_d    = FETCH;
         end
      end
   end

   assign o_rom_addr   = rom_addr_q;
   assign o_sccb_start = sccb_start_q;
   assign o_sccb_addr  = sccb_addr_q;
   assign o_sccb_data  = sccb_data_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;

endmodule

// File: tb/tb_cam_config.sv
// Directed bench for cam_config: a ROM model, an SCCB master model and a
// write scoreboard checked by an independent monitor.
module tb_cam_config;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cfg_start;
   logic [1:0]  rom_addr;
   logic [15:0] rom_data;
   logic        sccb_start;
   logic [7:0]  sccb_addr;
   logic [7:0]  sccb_data;
   logic        sccb_ready;
   logic        sccb_done;
   logic        busy;
   logic        done;

   logic [15:0] rom [4];
   int          lat = 3;
   int          cnt = 0;
   logic [15:0] sb [$];
   int          vectors = 0;
   int          miscompares = 0;
   int          accepts = 0;

   cam_config #(.ROM_DEPTH(4), .DELAY_CYCLES(8)) dut (
      .i_sysclk     (clk),
      .i_rstn       (rstn),
      .i_cfg_start  (cfg_start),
      .o_rom_addr   (rom_addr),
      .i_rom_data   (rom_data),
      .o_sccb_start (sccb_start),
      .o_sccb_addr  (sccb_addr),
      .o_sccb_data  (sccb_data),
      .i_sccb_ready (sccb_ready),
      .i_sccb_done  (sccb_done),
      .o_busy       (busy),
      .o_done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   // SCCB master: done pulses lat cycles after accept, or in the accept cycle when lat is 0.
   always @(posedge clk) begin
      if (sccb_start && sccb_ready) cnt <= lat;
      else if (cnt != 0) cnt <= cnt - 1;
   end
   assign sccb_done = (cnt == 1) || (lat == 0 && sccb_start && sccb_ready);

   always @(negedge clk) begin
      if (rstn && sccb_start && sccb_ready) begin
         logic [15:0] exp_w;
         accepts++;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected: got write %02h/%02h, required no write", sccb_addr, sccb_data);
         end else begin
            exp_w = sb.pop_front();
            if ({sccb_addr, sccb_data} !== exp_w) begin
               miscompares++;
               $display("FAIL sb_write: got %04h, required %04h", {sccb_addr, sccb_data}, exp_w);
            end else begin
               $display("write %02h/%02h ok", sccb_addr, sccb_data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
      end else begin
         $display("%s ok (%0h)", name, act);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 cfg_start = 1'b1;
      @(posedge clk); #1 cfg_start = 1'b0;
   endtask

   task automatic run_seq(input string tag, input int exp_first, input int exp_done);
      int  first = 0;
      int  dcyc  = 0;
      bit  gap   = 1'b0;
      pulse_start();
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk({tag, "_done_clr"}, done, 0);
            chk({tag, "_busy_set"}, busy, 1);
         end
         if (first == 0 && sccb_start) first = i;
         if (!done && !busy) gap = 1'b1;
         if (done) begin
            dcyc = i;
            break;
         end
      end
      chk({tag, "_first_write_cyc"}, first, exp_first);
      chk({tag, "_done_cyc"}, dcyc, exp_done);
      chk({tag, "_busy_gap"}, gap, 0);
      chk({tag, "_busy_end"}, busy, 0);
   endtask

   task automatic wait_first_start(input string tag, output int n);
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (sccb_start) begin
            n = i;
            break;
         end
      end
      chk({tag, "_start_seen"}, n != 0, 1);
   endtask

   task automatic wait_done(input string tag);
      int ok = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            break;
         end
      end
      chk({tag, "_done"}, ok, 1);
   endtask

   initial begin
      int n;
      int acc0;
      rstn       = 1'b0;
      cfg_start  = 1'b1;
      sccb_ready = 1'b1;
      for (int i = 0; i < 4; i++) rom[i] = 16'hFFFF;

      // Reset with a concurrent start request: the request must be discarded.
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      cfg_start = 1'b0;
      @(negedge clk);
      chk("rst_outputs", {rom_addr, sccb_start, sccb_addr, sccb_data, busy, done}, 0);
      repeat (3) @(negedge clk);
      chk("rst_start_discarded", {busy, sccb_start}, 0);

      // Two writes then end marker.
      rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
      lat = 3;
      sb.push_back(16'h1280); sb.push_back(16'h1101);
      run_seq("t1", 3, 16);

      // Delay marker first.
      rom[0] = 16'hFFF0; rom[1] = 16'h3A04; rom[2] = 16'hFFFF;
      sb.push_back(16'h3A04);
      run_seq("t2_delay", 13, 20);

      // No end marker: sequence stops at the last entry.
      rom[0] = 16'h0101; rom[1] = 16'h0202; rom[2] = 16'h0303; rom[3] = 16'h0404;
      sb.push_back(16'h0101); sb.push_back(16'h0202); sb.push_back(16'h0303); sb.push_back(16'h0404);
      run_seq("t3_nowrap", 3, 26);
      chk("t3_addr_last", rom_addr, 3);
      repeat (3) @(negedge clk);
      chk("t3_addr_held", rom_addr, 3);
      chk("t3_idle", {busy, sccb_start}, 0);

      // Backpressure: ready low while a write is pending.
      rom[0] = 16'h2233; rom[1] = 16'hFFFF; rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
      sb.push_back(16'h2233);
      acc0 = accepts;
      @(posedge clk); #1 sccb_ready = 1'b0;
      pulse_start();
      wait_first_start("t4", n);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold", {sccb_start, sccb_addr, sccb_data}, {1'b1, 16'h2233});
      end
      @(posedge clk); #1 sccb_ready = 1'b1;
      wait_done("t4");
      chk("t4_one_accept", accepts - acc0, 1);

      // Completion pulse in the accept cycle itself.
      rom[0] = 16'h4455;
      lat = 0;
      sb.push_back(16'h4455);
      run_seq("t5_zero_lat", 3, 8);

      // Ignored mid-sequence start, then reset during the write.
      rom[0] = 16'h7788; rom[1] = 16'h99AA; rom[2] = 16'hFFFF;
      lat = 5;
      sb.push_back(16'h7788);
      pulse_start();
      wait_first_start("t6", n);
      @(posedge clk); #1 cfg_start = 1'b1;
      @(posedge clk); #1 cfg_start = 1'b0; rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      chk("t6_rst_outputs", {rom_addr, sccb_start, sccb_addr, sccb_data, busy, done}, 0);
      repeat (4) @(negedge clk);
      chk("t6_late_done_ignored", {rom_addr, sccb_start, busy, done}, 0);
      sb.push_back(16'h7788); sb.push_back(16'h99AA);
      run_seq("t6_replay", 3, 20);

      repeat (5) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cam_config.md
CAM_CONFIG -- requirements
Module: cam_config

Interface
REQ-001 Parameter ROM_DEPTH, default 76: number of 16-bit config ROM entries; address width is ceil(log2(ROM_DEPTH)).
REQ-002 Parameter DELAY_CYCLES, default 1250000: i_sysclk cycles per delay entry (10 ms at 125 MHz); minimum 1.
REQ-003 One clock; reset is synchronous and active-low: i_sysclk and i_rstn.
REQ-004 i_sysclk  in  1  system clock; all logic on its rising edge.
REQ-005 i_rstn  in  1  synchronous active-low reset.
REQ-006 i_cfg_start  in  1  single-cycle request to run the ROM sequence from entry 0.
REQ-007 o_rom_addr  out  AW  config ROM read address.
REQ-008 i_rom_data  in  16  ROM entry {reg_addr[15:8], reg_data[7:0]}; valid exactly 1 cycle after o_rom_addr changes.
REQ-009 o_sccb_start  out  1  write request to the SCCB master; held until accepted.
REQ-010 o_sccb_addr  out  8  camera register address; stable while o_sccb_start is high.
REQ-011 o_sccb_data  out  8  camera register data; stable while o_sccb_start is high.
REQ-012 i_sccb_ready  in  1  SCCB master idle; a write is accepted in a cycle where o_sccb_start and i_sccb_ready are both high.
REQ-013 i_sccb_done  in  1  single-cycle pulse when an accepted write completes on the bus.
REQ-014 o_busy  out  1  high from sequence start until sequence end.
REQ-015 o_done  out  1  high once a sequence has completed; cleared when a new sequence starts.

Function
REQ-016 States: IDLE, FETCH, DECODE, WRITE, WAIT_DONE, DELAY, FINISH.
REQ-017 IDLE: i_cfg_start=1 -> o_rom_addr<=0, o_done<=0, o_busy<=1, go FETCH; otherwise stay.
REQ-018 FETCH: one cycle covering ROM latency; go DECODE.
REQ-019 DECODE, i_rom_data==16'hFFFF (end marker): go FINISH.
REQ-020 DECODE, i_rom_data==16'hFFF0 (delay marker): load delay counter with DELAY_CYCLES-1, go DELAY.
REQ-021 DECODE, any other value: latch o_sccb_addr/o_sccb_data from i_rom_data, assert o_sccb_start, go WRITE.
REQ-022 WRITE: hold o_sccb_start until the accept cycle (start && ready); deassert it the following cycle; go WAIT_DONE.
REQ-023 WAIT_DONE: on i_sccb_done advance entry; an i_sccb_done arriving in the accept cycle itself counts.
REQ-024 DELAY: decrement each cycle; at 0 advance entry; total DELAY state duration exactly DELAY_CYCLES cycles.
REQ-025 Advance entry: if o_rom_addr==ROM_DEPTH-1 go FINISH (no wrap); else o_rom_addr<=o_rom_addr+1, go FETCH.
REQ-026 FINISH: o_busy<=0, o_done<=1, go IDLE; o_done stays high until the next accepted i_cfg_start.
REQ-027 i_cfg_start is ignored in every state except IDLE; no queuing, no restart mid-sequence.
REQ-028 i_sccb_done outside WRITE/WAIT_DONE is ignored.
REQ-029 Cost per write entry: 2 cycles (FETCH, DECODE) plus handshake and bus time; no extra bubbles.
REQ-030 Delay marker and end marker are never forwarded to the SCCB master.

Reset
REQ-031 i_rstn low at any clock edge: state IDLE, o_rom_addr 0, o_sccb_start 0, o_sccb_addr 0, o_sccb_data 0, o_busy 0, o_done 0, delay counter 0.
REQ-032 Reset mid-write drops o_sccb_start on the next edge; a late i_sccb_done after reset is ignored.
REQ-033 i_cfg_start sampled in the same cycle as reset is discarded.

Verification
REQ-034 ROM {0x1280, 0x1101, 0xFFFF}, ready tied 1, done 3 cycles after accept, start pulse -> two writes (0x12/0x80, 0x11/0x01) in order, o_busy high throughout, o_done rises one cycle after end marker decode.
REQ-035 DELAY_CYCLES=8, ROM {0xFFF0, 0x3A04, 0xFFFF} -> no SCCB activity for exactly 8 cycles in DELAY, then write 0x3A/0x04, then o_done=1.
REQ-036 i_sccb_ready held low 5 cycles during WRITE -> o_sccb_start, o_sccb_addr, o_sccb_data stable all 5 cycles; single accept; exactly one write issued.
REQ-037 ROM_DEPTH=4, no end marker, all entries writes -> 4 writes at addresses 0..3, o_rom_addr stops at 3, o_done=1, no wrap to 0.
REQ-038 i_cfg_start pulsed during WAIT_DONE, then i_rstn low for 1 cycle mid-write -> start ignored; after reset all outputs 0, state IDLE; next start replays from entry 0.
